// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared definitions for the memory-access stage and the control unit:
// state encodings and the default read latency.
package unidade_acesso_memoria_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESCREVE  = 2'd1,
        LE       = 2'd2,
        RESPONDE = 2'd3
    } estado_t;

    localparam int unsigned LAT_LEITURA_PADRAO = 1;

endpackage

// File: rtl/unidade_acesso_memoria.sv
// Memory-access stage: accepts load/store requests, drives the data-memory port set,
// and returns load data over a held response handshake.
module unidade_acesso_memoria
    import unidade_acesso_memoria_pkg::*;
#(
    parameter int unsigned LAT_LEITURA = LAT_LEITURA_PADRAO
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ReqValido,
    output logic       ReqPronto,
    input  logic       ReqEscrita,
    input  logic [7:0] ReqBase,
    input  logic [7:0] ReqDesloc,
    input  logic [7:0] ReqDado,
    output logic       RespValido,
    input  logic       RespPronto,
    output logic [7:0] RespDado,
    output logic [7:0] Endereco,
    output logic [7:0] DadoEscr,
    input  logic [7:0] DadoLido,
    output logic       MenWrite,
    output logic       MenRead
);

    // Counter runs 0..LAT_LEITURA-1; the last value marks the sampling edge.
    localparam logic [1:0] ULTIMO = 2'(LAT_LEITURA - 1);

    estado_t    estado_q, estado_d;
    logic [1:0] cont_q, cont_d;
    logic [7:0] end_q, end_d;
    logic [7:0] escr_q, escr_d;
    logic [7:0] resp_q, resp_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q <= OCIOSO;
            cont_q   <= 2'd0;
            end_q    <= 8'h00;
            escr_q   <= 8'h00;
            resp_q   <= 8'h00;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            end_q    <= end_d;
            escr_q   <= escr_d;
            resp_q   <= resp_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        cont_d     = cont_q;
        end_d      = end_q;
        escr_d     = escr_q;
        resp_d     = resp_q;
        ReqPronto  = 1'b0;
        RespValido = 1'b0;
        MenWrite   = 1'b0;
        MenRead    = 1'b0;

        unique case (estado_q)
            OCIOSO: begin
                ReqPronto = 1'b1;
                if (ReqValido) begin
                    end_d = ReqBase + ReqDesloc;
                    // Write data only moves on stores so DadoEscr keeps its last store value.
                    if (ReqEscrita) begin
                        escr_d   = ReqDado;
                        estado_d = ESCREVE;
                    end else begin
                        cont_d   = 2'd0;
                        estado_d = LE;
                    end
                end
            end
            ESCREVE: begin
                MenWrite = 1'b1;
                estado_d = OCIOSO;
            end
            LE: begin
                MenRead = 1'b1;
                if (cont_q == ULTIMO) begin
                    resp_d   = DadoLido;
                    cont_d   = 2'd0;
                    estado_d = RESPONDE;
                end else begin
                    cont_d = cont_q + 2'd1;
                end
            end
            RESPONDE: begin
                RespValido = 1'b1;
                if (RespPronto) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign Endereco = end_q;
    assign DadoEscr = escr_q;
    assign RespDado = resp_q;

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Directed bench: table of load/store vectors against a memory model, plus
// reset-mid-load, back-pressure, wrap, LAT_LEITURA=3 and a full address sweep.
module tb_unidade_acesso_memoria;

    logic clk;
    logic rst_n;

    // Instance with LAT_LEITURA=1, backed by a bench memory model.
    logic       req_valido, req_pronto, req_escrita, resp_valido, resp_pronto;
    logic [7:0] req_base, req_desloc, req_dado, resp_dado, endereco, dado_escr, dado_lido;
    logic       men_write, men_read;

    // Instance with LAT_LEITURA=3, read data driven directly by the bench.
    logic       req_valido3, req_pronto3, resp_valido3, resp_pronto3;
    logic [7:0] req_base3, req_desloc3, resp_dado3, endereco3, dado_escr3, dado_lido3;
    logic       men_write3, men_read3;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    unidade_acesso_memoria #(.LAT_LEITURA(1)) dut1 (
        .Clock      (clk),
        .Reset      (rst_n),
        .ReqValido  (req_valido),
        .ReqPronto  (req_pronto),
        .ReqEscrita (req_escrita),
        .ReqBase    (req_base),
        .ReqDesloc  (req_desloc),
        .ReqDado    (req_dado),
        .RespValido (resp_valido),
        .RespPronto (resp_pronto),
        .RespDado   (resp_dado),
        .Endereco   (endereco),
        .DadoEscr   (dado_escr),
        .DadoLido   (dado_lido),
        .MenWrite   (men_write),
        .MenRead    (men_read)
    );

    unidade_acesso_memoria #(.LAT_LEITURA(3)) dut3 (
        .Clock      (clk),
        .Reset      (rst_n),
        .ReqValido  (req_valido3),
        .ReqPronto  (req_pronto3),
        .ReqEscrita (1'b0),
        .ReqBase    (req_base3),
        .ReqDesloc  (req_desloc3),
        .ReqDado    (8'h00),
        .RespValido (resp_valido3),
        .RespPronto (resp_pronto3),
        .RespDado   (resp_dado3),
        .Endereco   (endereco3),
        .DadoEscr   (dado_escr3),
        .DadoLido   (dado_lido3),
        .MenWrite   (men_write3),
        .MenRead    (men_read3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (men_write) mem[endereco] <= dado_escr;
    end
    assign dado_lido = mem[endereco];

    always @(negedge clk) begin
        checks++;
        if ((men_write && men_read) || (men_write3 && men_read3)) begin
            errors++;
            $display("FAIL excl_rw: got wr=%b rd=%b wr3=%b rd3=%b, required never both high",
                     men_write, men_read, men_write3, men_read3);
        end
    end

    task automatic chk(input string nome, input logic [7:0] obtido, input logic [7:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", nome, obtido, esperado, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_pronto", {7'd0, req_pronto}, 8'h01);
        chk("rst_resp_valido", {7'd0, resp_valido}, 8'h00);
        chk("rst_resp_dado", resp_dado, 8'h00);
        chk("rst_endereco", endereco, 8'h00);
        chk("rst_dado_escr", dado_escr, 8'h00);
        chk("rst_men_write", {7'd0, men_write}, 8'h00);
        chk("rst_men_read", {7'd0, men_read}, 8'h00);
    endtask

    // One full transaction on dut1; espera > 0 adds response back-pressure cycles.
    task automatic transacao(input logic esc, input logic [7:0] base, input logic [7:0] desl,
                             input logic [7:0] dado, input logic [7:0] end_esp,
                             input logic [7:0] resp_esp, input int espera);
        @(negedge clk);
        chk("req_pronto_idle", {7'd0, req_pronto}, 8'h01);
        req_valido  = 1'b1;
        req_escrita = esc;
        req_base    = base;
        req_desloc  = desl;
        req_dado    = dado;
        @(negedge clk);
        req_valido = 1'b0;
        if (esc) begin
            chk("st_men_write", {7'd0, men_write}, 8'h01);
            chk("st_men_read", {7'd0, men_read}, 8'h00);
            chk("st_endereco", endereco, end_esp);
            chk("st_dado_escr", dado_escr, dado);
            @(negedge clk);
            chk("st_men_write_off", {7'd0, men_write}, 8'h00);
            chk("st_req_pronto_t2", {7'd0, req_pronto}, 8'h01);
        end else begin
            chk("ld_men_read", {7'd0, men_read}, 8'h01);
            chk("ld_men_write", {7'd0, men_write}, 8'h00);
            chk("ld_endereco", endereco, end_esp);
            chk("ld_resp_valido_early", {7'd0, resp_valido}, 8'h00);
            // Early RespPronto while still in LE must not skip the response.
            if (espera > 0) resp_pronto = 1'b1;
            @(negedge clk);
            resp_pronto = 1'b0;
            for (int k = 0; k < espera; k++) begin
                req_valido  = 1'b1;
                req_escrita = 1'b1;
                chk("bp_resp_valido", {7'd0, resp_valido}, 8'h01);
                chk("bp_resp_dado", resp_dado, resp_esp);
                chk("bp_req_pronto", {7'd0, req_pronto}, 8'h00);
                chk("bp_men_read", {7'd0, men_read}, 8'h00);
                chk("bp_men_write", {7'd0, men_write}, 8'h00);
                @(negedge clk);
            end
            req_valido = 1'b0;
            chk("ld_resp_valido", {7'd0, resp_valido}, 8'h01);
            chk("ld_resp_dado", resp_dado, resp_esp);
            resp_pronto = 1'b1;
            @(negedge clk);
            resp_pronto = 1'b0;
            chk("ld_resp_consumed", {7'd0, resp_valido}, 8'h00);
            chk("ld_req_pronto_back", {7'd0, req_pronto}, 8'h01);
        end
    endtask

    typedef struct {
        logic       esc;
        logic [7:0] base;
        logic [7:0] desl;
        logic [7:0] dado;
        logic [7:0] end_esp;
        logic [7:0] resp_esp;
    } vetor_t;

    vetor_t tab [9];

    initial begin
        tab[0] = '{1'b1, 8'h10, 8'h05, 8'hA5, 8'h15, 8'h00};
        tab[1] = '{1'b0, 8'h15, 8'h00, 8'h00, 8'h15, 8'hA5};
        tab[2] = '{1'b1, 8'hFF, 8'h01, 8'h3C, 8'h00, 8'h00};
        tab[3] = '{1'b1, 8'hF0, 8'h0F, 8'hC3, 8'hFF, 8'h00};
        tab[4] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hC3};
        tab[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 8'h3C};
        tab[6] = '{1'b1, 8'h20, 8'hF0, 8'h5A, 8'h10, 8'h00};
        tab[7] = '{1'b0, 8'h05, 8'h0B, 8'h00, 8'h10, 8'h5A};
        tab[8] = '{1'b0, 8'h10, 8'h05, 8'h00, 8'h15, 8'hA5};

        rst_n        = 1'b0;
        req_valido   = 1'b0;
        req_escrita  = 1'b0;
        req_base     = 8'h00;
        req_desloc   = 8'h00;
        req_dado     = 8'h00;
        resp_pronto  = 1'b0;
        req_valido3  = 1'b0;
        req_base3    = 8'h00;
        req_desloc3  = 8'h00;
        resp_pronto3 = 1'b0;
        dado_lido3   = 8'h00;

        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tab[i]) begin
            transacao(tab[i].esc, tab[i].base, tab[i].desl, tab[i].dado,
                      tab[i].end_esp, tab[i].resp_esp, 0);
        end

        // Back-pressure: response held 5 cycles, then a single consumption.
        transacao(1'b0, 8'h15, 8'h00, 8'h00, 8'h15, 8'hA5, 5);
        @(negedge clk);
        chk("bp_no_second_resp", {7'd0, resp_valido}, 8'h00);
        chk("bp_no_stray_write", {7'd0, men_write}, 8'h00);

        // Reset asserted during LE: outputs return to reset values without a clock edge.
        @(negedge clk);
        req_valido  = 1'b1;
        req_escrita = 1'b0;
        req_base    = 8'h15;
        req_desloc  = 8'h00;
        @(negedge clk);
        req_valido = 1'b0;
        chk("rml_men_read", {7'd0, men_read}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rml_no_resp", {7'd0, resp_valido}, 8'h00);
            chk("rml_req_pronto", {7'd0, req_pronto}, 8'h01);
        end

        // LAT_LEITURA=3: sample must be the value present during the third MenRead cycle.
        @(negedge clk);
        req_valido3 = 1'b1;
        req_base3   = 8'h20;
        req_desloc3 = 8'h03;
        @(negedge clk);
        req_valido3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("l3_men_read", {7'd0, men_read3}, 8'h01);
            chk("l3_endereco", endereco3, 8'h23);
            chk("l3_resp_valido_early", {7'd0, resp_valido3}, 8'h00);
            dado_lido3 = 8'(k * 8'h11);
            @(negedge clk);
        end
        dado_lido3 = 8'h44;
        chk("l3_men_read_off", {7'd0, men_read3}, 8'h00);
        chk("l3_resp_valido", {7'd0, resp_valido3}, 8'h01);
        chk("l3_resp_dado", resp_dado3, 8'h33);
        resp_pronto3 = 1'b1;
        @(negedge clk);
        resp_pronto3 = 1'b0;
        chk("l3_consumed", {7'd0, resp_valido3}, 8'h00);
        chk("l3_req_pronto", {7'd0, req_pronto3}, 8'h01);

        // Full sweep: write ~i to every address, then read everything back.
        for (int i = 0; i < 256; i++) begin
            transacao(1'b1, 8'(i - 7), 8'h07, ~8'(i), 8'(i), 8'h00, 0);
        end
        for (int i = 0; i < 256; i++) begin
            transacao(1'b0, 8'(i), 8'h00, 8'h00, 8'(i), ~8'(i), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_acesso_memoria.md
# unidade_acesso_memoria

Memory-access stage for the 8-bit processor, sitting directly upstream of the data memory. It accepts load/store requests from the execute stage over a valid/ready handshake, computes the effective address, and drives the data memory's Endereco/DadoEscr/MenWrite/MenRead port set. For loads it captures DadoLido after a configurable latency and returns it over a held response handshake.

## Interface
- LAT_LEITURA, default 1: cycles from first MenRead-high cycle to the edge that samples DadoLido; legal range 1..4.
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low; one clock domain.
- ReqValido  in  1  request present.
- ReqPronto  out  1  unit can accept a request this cycle.
- ReqEscrita  in  1  1 = store, 0 = load.
- ReqBase  in  8  base address, unsigned.
- ReqDesloc  in  8  offset, two's complement.
- ReqDado  in  8  store data.
- RespValido  out  1  load data available.
- RespPronto  in  1  consumer takes load data.
- RespDado  out  8  load result.
- Endereco  out  8  data-memory address.
- DadoEscr  out  8  data-memory write data.
- DadoLido  in  8  data-memory read data.
- MenWrite  out  1  data-memory write enable.
- MenRead  out  1  data-memory read enable.

## Operation
- States: OCIOSO, ESCREVE, LE, RESPONDE.
- OCIOSO: ReqPronto=1. On ReqValido&ReqPronto at an edge, latch address = (ReqBase + ReqDesloc) mod 256, ReqDado, and ReqEscrita. Go to ESCREVE on a store, or to LE on a load.
- ESCREVE: MenWrite=1, MenRead=0, Endereco/DadoEscr = latched values for exactly one cycle; return to OCIOSO. Stores produce no response.
- LE: MenRead=1, MenWrite=0, Endereco = latched address, held for LAT_LEITURA cycles (internal counter). At the edge ending the last LE cycle, register DadoLido into RespDado and go to RESPONDE.
- RESPONDE: RespValido=1, RespDado stable; ReqPronto=0. On RespPronto at an edge, go to OCIOSO.
- MenWrite and MenRead are never both 1. Outside ESCREVE/LE both are 0; Endereco and DadoEscr hold their last values.
- Address arithmetic is 8-bit and wraps: 0xFF + 0x01 = 0x00; 0x00 + 0xFF (-1) = 0xFF.

## Timing
- Reset low (any time, including mid-access): state = OCIOSO, counter = 0, ReqPronto=1, RespValido=0, RespDado=0, Endereco=0, DadoEscr=0, MenWrite=0, MenRead=0, all immediately. Any in-flight request is dropped; a write whose MenWrite-high cycle was cut off is not completed.
- Store accepted at edge t: MenWrite high during cycle t+1; ReqPronto high again in cycle t+2. Throughput is 1 store per 2 cycles.
- Load accepted at edge t: MenRead high in cycles t+1..t+LAT_LEITURA; RespValido high from cycle t+LAT_LEITURA+1 until the edge where RespPronto=1. The earliest next accept is the edge after that.
- RespPronto asserted before RespValido has no effect.
- Request inputs are ignored outside OCIOSO, so no buffering is needed.

## Structure
- The shared definitions header holds state encodings (2-bit: OCIOSO=0, ESCREVE=1, LE=2, RESPONDE=3) and the LAT_LEITURA default. The processor's control unit uses the same header.
- The block is a single module; no sub-module is needed. The data memory is instantiated beside it at the datapath level, not inside it.

## Test plan
- Reset mid-load (Reset low during LE) -> all outputs reset values within the same cycle; after release, ReqPronto=1 and no RespValido pulse.
- Store base 0x10, desloc 0x05, dado 0xA5 -> one cycle with MenWrite=1, Endereco=0x15, DadoEscr=0xA5; then a load of 0x15 -> RespDado=0xA5, RespValido at cycle t+2 (LAT_LEITURA=1).
- Wrap: store base 0xFF, desloc 0x01 -> Endereco=0x00. Load base 0x00, desloc 0xFF -> Endereco=0xFF.
- Response back-pressure: RespPronto held low 5 cycles -> RespValido and RespDado stable, ReqPronto=0, MenRead=0 throughout. Then one RespPronto pulse -> single consumption.
- LAT_LEITURA=3: load -> MenRead high exactly 3 cycles; RespDado equals DadoLido as sampled at the end of the third cycle.
- Sweep: store addr=i, data=~i for all 256 addresses, then load all 256 -> every RespDado = ~i; MenWrite and MenRead never high together.
